ibex_cheri_tag_ctrl: RTL and testbench
======================================

# ibex_cheri_tag_ctrl

Sequencer and arbiter for the single-ported CHERI tag memory. It shares the tag port between the load/store unit (LSU), which reads and writes individual tags, and a built-in clear engine, which zeroes a contiguous range of tags for revocation and memory scrubbing. The block sits between the LSU's capability path and the tag memory instance, and it is the only master of that memory.

## Interface
Parameters:
- TAG_MEM_SIZE, 128000: number of tag entries; must match the tag memory instance.
- STARVE_LIMIT, 4: maximum consecutive LSU grants while a clear is pending; legal range is 1..15.

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- rst_i  in  1  reset, asynchronous, active-high.
- lsu_req_i  in  1  LSU tag access request.
- lsu_we_i  in  1  1 = write, 0 = read.
- lsu_addr_i  in  32  tag index.
- lsu_wdata_i  in  1  tag value to write.
- lsu_gnt_o  out  1  combinational grant; the access is issued in this cycle.
- lsu_rvalid_o  out  1  read response valid.
- lsu_rdata_o  out  1  read tag value.
- clr_start_i  in  1  single-cycle pulse that starts a clear.
- clr_base_i  in  32  first tag index to clear; sampled on start.
- clr_count_i  in  32  number of tags to clear; sampled on start.
- clr_abort_i  in  1  stops an active clear.
- clr_busy_o  out  1  clear in progress.
- clr_done_o  out  1  single-cycle completion pulse.
- tag_addr_o  out  32  tag memory address.
- tag_we_o  out  1  tag memory write enable.
- tag_wdata_o  out  1  tag memory write data.
- tag_rdata_i  in  1  tag memory read data; registered, valid 1 cycle after the read is issued.

## Operation
- Clear engine FSM has three states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on clr_start_i. On this transition the engine latches cur = clr_base_i and computes end = min(clr_base_i + clr_count_i, TAG_MEM_SIZE).
    - The sum is computed at 33 bits, so there is no 32-bit wrap.
    - If cur >= end (count 0, or base out of range), the FSM goes IDLE -> DONE instead.
  - SWEEP: each cycle the engine owns the port, it drives tag_we_o=1, tag_wdata_o=0, tag_addr_o=cur, then increments cur. When the incremented cur equals end, the FSM goes to DONE.
  - SWEEP -> DONE on clr_abort_i. Any write issued in that same cycle still completes.
  - DONE -> IDLE unconditionally after 1 cycle.
- clr_start_i is ignored unless the FSM is in IDLE. clr_abort_i is ignored in IDLE and DONE.
- Output decodes:
  - clr_busy_o = (state == SWEEP).
  - clr_done_o = (state == DONE).
- Arbitration, evaluated each cycle:
  - Not in SWEEP: lsu_gnt_o = lsu_req_i. The port carries the LSU access.
  - In SWEEP with starve_cnt < STARVE_LIMIT and lsu_req_i=1: the LSU is granted and starve_cnt increments.
  - In SWEEP otherwise: the clear engine takes the port, lsu_gnt_o=0, and starve_cnt resets to 0.
  - starve_cnt is also reset to 0 on entering SWEEP.
- Idle port: when nothing is granted, tag_we_o=0 and tag_addr_o holds its last value.
- LSU read response: lsu_rvalid_o is registered high exactly 1 cycle after a granted read, with lsu_rdata_o = tag_rdata_i. A granted write produces no response.
- The LSU must hold its request fields stable until it sees lsu_gnt_o=1.
- Ordering is strict issue order. A read granted after a clear write to the same index returns 0.

## Timing
- Reset values: state=IDLE, starve_cnt=0, cur=0, lsu_rvalid_o=0, clr_busy_o=0, clr_done_o=0, tag_we_o=0.
- Reset asserted mid-sweep returns to IDLE immediately with no done pulse. Tags already cleared stay cleared.
- Grant to memory issue: same cycle. Read data latency: 1 cycle after grant.
- Start to first clear write: the write happens on the cycle after clr_start_i, if the LSU is idle.
- Clear duration with no LSU traffic: N writes take N cycles. clr_done_o pulses on the cycle after the last write.
- Worst-case clear duration: N*(STARVE_LIMIT+1) cycles.
- Worst-case LSU wait during a sweep: 1 cycle per STARVE_LIMIT grants.
- Start and abort in the same cycle: start wins and the abort is ignored.

## Test plan
- LSU write tag 5 =1, then read tag 5: gnt is high both cycles; rvalid pulses 1 cycle after the read with rdata=1; the write produces no rvalid.
- Clear base=10 count=4, no LSU traffic: tag_we_o=1 with wdata 0 at addresses 10, 11, 12, 13 on consecutive cycles; busy is high for 4 cycles; done pulses on cycle 5; tags 9 and 14 are untouched.
- Clear count=100 with lsu_req_i held high and STARVE_LIMIT=4: the grant pattern is 4 LSU then 1 clear, repeating; the clear finishes in 500 cycles.
- Clear base=127998 count=10: only 127998 and 127999 are written, then done. A clear with count=0 gives a done pulse the cycle after start and no writes.
- Abort at the third sweep cycle of base=0 count=50: exactly 3 tags are cleared, done pulses once, and a new start in the following IDLE cycle is accepted.
- Assert rst_i mid-sweep: busy, done and rvalid go low asynchronously; after reset release a fresh clear runs normally.

Source files
------------

// File: rtl/ibex_cheri_tag_ctrl.sv
// ibex_cheri_tag_ctrl
// Sole master of the single-ported CHERI tag memory. Arbitrates the port
// between LSU tag accesses and a clear engine that zeroes a contiguous
// range of tags (revocation / scrubbing).
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   lsu_req_i/we_i/addr_i/wdata_i   LSU tag access request
//   lsu_gnt_o               combinational grant (access issued this cycle)
//   lsu_rvalid_o/rdata_o    read response, one cycle after a granted read
//   clr_start_i/base_i/count_i/abort_i   clear engine control
//   clr_busy_o, clr_done_o  clear in progress / one-cycle completion pulse
//   tag_addr_o/we_o/wdata_o/rdata_i      tag memory port
module ibex_cheri_tag_ctrl #(
  parameter int unsigned TAG_MEM_SIZE = 128000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic        lsu_rdata_o,
  input  logic        clr_start_i,
  input  logic [31:0] clr_base_i,
  input  logic [31:0] clr_count_i,
  input  logic        clr_abort_i,
  output logic        clr_busy_o,
  output logic        clr_done_o,
  output logic [31:0] tag_addr_o,
  output logic        tag_we_o,
  output logic        tag_wdata_o,
  input  logic        tag_rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [32:0] MEM_END    = 33'(TAG_MEM_SIZE);
  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [31:0] cur_q, cur_d;
  logic [32:0] end_q, end_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] addr_q;
  logic        rvalid_q;

  logic [32:0] clr_sum;
  logic [32:0] clr_end;
  logic [32:0] cur_inc;
  logic        lsu_gnt;
  logic        clr_own;

  // End index is formed at 33 bits so base + count cannot wrap, then
  // clamped to the memory size.
  always_comb begin
    clr_sum = {1'b0, clr_base_i} + {1'b0, clr_count_i};
    clr_end = (clr_sum > MEM_END) ? MEM_END : clr_sum;
    cur_inc = {1'b0, cur_q} + 33'd1;
  end

  // Outside a sweep the LSU has the port outright; during a sweep it may
  // win at most STARVE_LIMIT times in a row before the clear engine gets
  // a slot.
  always_comb begin
    if (state_q == SWEEP) begin
      lsu_gnt = lsu_req_i && (starve_q < STARVE_MAX);
    end else begin
      lsu_gnt = lsu_req_i;
    end
    clr_own = (state_q == SWEEP) && !lsu_gnt;
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    end_d    = end_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        starve_d = '0;
        if (clr_start_i) begin
          cur_d   = clr_base_i;
          end_d   = clr_end;
          state_d = ({1'b0, clr_base_i} >= clr_end) ? DONE : SWEEP;
        end
      end
      SWEEP: begin
        if (lsu_gnt) begin
          starve_d = starve_q + 4'd1;
        end else begin
          starve_d = '0;
          cur_d    = cur_inc[31:0];
          if (cur_inc == end_q) begin
            state_d = DONE;
          end
        end
        // A write issued in the abort cycle still goes out on the port.
        if (clr_abort_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        starve_d = '0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      end_q    <= '0;
      starve_q <= '0;
      addr_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      end_q    <= end_d;
      starve_q <= starve_d;
      addr_q   <= tag_addr_o;
      rvalid_q <= lsu_gnt && !lsu_we_i;
    end
  end

  // Port mux; the address holds its previous value when nobody is granted.
  always_comb begin
    tag_we_o    = 1'b0;
    tag_wdata_o = 1'b0;
    tag_addr_o  = addr_q;
    if (lsu_gnt) begin
      tag_we_o    = lsu_we_i;
      tag_wdata_o = lsu_wdata_i;
      tag_addr_o  = lsu_addr_i;
    end else if (clr_own) begin
      tag_we_o    = 1'b1;
      tag_wdata_o = 1'b0;
      tag_addr_o  = cur_q;
    end
  end

  assign lsu_gnt_o    = lsu_gnt;
  assign lsu_rvalid_o = rvalid_q;
  assign lsu_rdata_o  = tag_rdata_i;
  assign clr_busy_o   = (state_q == SWEEP);
  assign clr_done_o   = (state_q == DONE);

endmodule

// File: tb/tb_ibex_cheri_tag_ctrl.sv
// Testbench for ibex_cheri_tag_ctrl: drives LSU and clear traffic against a
// behavioural tag memory and checks results against a reference tag map.
module tb_ibex_cheri_tag_ctrl;
  localparam int unsigned SIZE = 128000;
  localparam int unsigned L    = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i, lsu_wdata_i;
  logic [31:0] lsu_addr_i;
  logic        lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o;
  logic        clr_start_i, clr_abort_i;
  logic [31:0] clr_base_i, clr_count_i;
  logic        clr_busy_o, clr_done_o;
  logic [31:0] tag_addr_o;
  logic        tag_we_o, tag_wdata_o;
  logic        tag_rdata_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ibex_cheri_tag_ctrl #(
    .TAG_MEM_SIZE(SIZE),
    .STARVE_LIMIT(L)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .clr_start_i(clr_start_i), .clr_base_i(clr_base_i),
    .clr_count_i(clr_count_i), .clr_abort_i(clr_abort_i),
    .clr_busy_o(clr_busy_o), .clr_done_o(clr_done_o),
    .tag_addr_o(tag_addr_o), .tag_we_o(tag_we_o),
    .tag_wdata_o(tag_wdata_o), .tag_rdata_i(tag_rdata_i)
  );

  // Tag memory: registered read, one access per cycle.
  bit tmem [0:SIZE-1];
  always @(posedge clk_i) begin
    if (tag_addr_o < SIZE) begin
      if (tag_we_o) tmem[tag_addr_o] <= tag_wdata_o;
      else          tag_rdata_i <= tmem[tag_addr_o];
    end
  end

  // Log of clear-engine writes and done pulses.
  int unsigned clr_log[$];
  int done_pulses = 0;
  always @(posedge clk_i) begin
    if (!rst_i && tag_we_o && !lsu_gnt_o) clr_log.push_back(tag_addr_o);
    if (clr_done_o) done_pulses <= done_pulses + 1;
  end

  // Reference tag map; absent entries read as 0.
  bit ref_mem [int unsigned];
  function automatic bit ref_get(int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : 1'b0;
  endfunction
  function automatic void ref_clear(int unsigned base, int unsigned count);
    longint unsigned e = longint'(base) + longint'(count);
    if (e > SIZE) e = SIZE;
    for (longint unsigned a = base; a < e; a++) ref_mem[int'(a)] = 1'b0;
  endfunction

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic lsu_write(input int unsigned a, input bit v);
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = a; lsu_wdata_i = v;
    #1;
    checks++;
    if (lsu_gnt_o !== 1'b1) begin errors++; $display("FAIL preload_gnt addr %0d got %b exp 1", a, lsu_gnt_o); end
    step;
    lsu_req_i = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic pulse_start(input int unsigned base, input int unsigned count);
    clr_base_i = base; clr_count_i = count; clr_start_i = 1'b1;
    step;
    clr_start_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    lsu_req_i = 0; lsu_we_i = 0; lsu_addr_i = '0; lsu_wdata_i = 0;
    clr_start_i = 0; clr_abort_i = 0; clr_base_i = '0; clr_count_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (clr_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", clr_busy_o); end
    checks++; if (clr_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", clr_done_o); end
    checks++; if (lsu_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", lsu_rvalid_o); end
    checks++; if (tag_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", tag_we_o); end
    checks++; if (lsu_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0", lsu_gnt_o); end
    rst_i = 1'b0;
    step;
  endtask

  task automatic test_lsu_rw;
    bit pend, pend_val;
    lsu_req_i = 1; lsu_we_i = 1; lsu_addr_i = 5; lsu_wdata_i = 1;
    #1;
    checks++; if (lsu_gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b exp 1", lsu_gnt_o); end
    checks++; if (tag_we_o !== 1'b1 || tag_addr_o !== 32'd5 || tag_wdata_o !== 1'b1) begin
      errors++; $display("FAIL wr_port got we=%b addr=%0d wd=%b exp we=1 addr=5 wd=1", tag_we_o, tag_addr_o, tag_wdata_o); end
    step;
    ref_mem[5] = 1'b1;
    checks++; if (lsu_rvalid_o !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %b exp 0", lsu_rvalid_o); end
    lsu_we_i = 0;
    #1;
    checks++; if (lsu_gnt_o !== 1'b1 || tag_we_o !== 1'b0) begin
      errors++; $display("FAIL rd_gnt got gnt=%b we=%b exp gnt=1 we=0", lsu_gnt_o, tag_we_o); end
    step;
    lsu_req_i = 0;
    checks++; if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== 1'b1) begin
      errors++; $display("FAIL rd_resp got v=%b d=%b exp v=1 d=1", lsu_rvalid_o, lsu_rdata_o); end
    step;
    checks++; if (lsu_rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_pulse got %b exp 0", lsu_rvalid_o); end
    // Random back-to-back accesses over a small window.
    pend = 0; pend_val = 0;
    for (int i = 0; i < 41; i++) begin
      if (i < 40) begin
        lsu_req_i = 1'($urandom_range(0, 3) != 0);
        lsu_we_i = 1'($urandom_range(0, 1)); lsu_addr_i = $urandom_range(0, 15);
        lsu_wdata_i = 1'($urandom_range(0, 1));
      end else lsu_req_i = 0;
      #1;
      checks++; if (lsu_rvalid_o !== pend || (pend && lsu_rdata_o !== pend_val)) begin
        errors++; $display("FAIL rand_rd got v=%b d=%b exp v=%b d=%b", lsu_rvalid_o, lsu_rdata_o, pend, pend_val); end
      checks++; if (lsu_gnt_o !== lsu_req_i) begin
        errors++; $display("FAIL rand_gnt got %b exp %b", lsu_gnt_o, lsu_req_i); end
      pend = lsu_req_i && !lsu_we_i;
      if (pend) pend_val = ref_get(lsu_addr_i);
      if (lsu_req_i && lsu_we_i) ref_mem[lsu_addr_i] = lsu_wdata_i;
      step;
    end
  endtask

  task automatic test_clear_basic;
    int mark, dmark;
    for (int unsigned a = 9; a <= 14; a++) lsu_write(a, 1'b1);
    mark = clr_log.size(); dmark = done_pulses;
    clr_base_i = 10; clr_count_i = 4; clr_start_i = 1;
    #1;
    checks++; if (clr_busy_o !== 1'b0 || tag_we_o !== 1'b0) begin
      errors++; $display("FAIL clr_start_cycle got busy=%b we=%b exp 0 0", clr_busy_o, tag_we_o); end
    step;
    clr_start_i = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      checks++; if (clr_busy_o !== 1'b1 || tag_we_o !== 1'b1 || tag_wdata_o !== 1'b0 || tag_addr_o !== 10 + i || clr_done_o !== 1'b0) begin
        errors++; $display("FAIL clr_write%0d got busy=%b we=%b wd=%b addr=%0d done=%b exp 1 1 0 %0d 0",
                           i, clr_busy_o, tag_we_o, tag_wdata_o, tag_addr_o, clr_done_o, 10 + i); end
      step;
    end
    checks++; if (clr_done_o !== 1'b1 || clr_busy_o !== 1'b0 || tag_we_o !== 1'b0) begin
      errors++; $display("FAIL clr_done got done=%b busy=%b we=%b exp 1 0 0", clr_done_o, clr_busy_o, tag_we_o); end
    step;
    checks++; if (clr_done_o !== 1'b0) begin errors++; $display("FAIL clr_done_pulse got %b exp 0", clr_done_o); end
    ref_clear(10, 4);
    for (int unsigned a = 9; a <= 14; a++) begin
      checks++; if (tmem[a] !== ref_get(a)) begin errors++; $display("FAIL clr_mem[%0d] got %b exp %b", a, tmem[a], ref_get(a)); end
    end
    checks++; if (clr_log.size() - mark != 4 || done_pulses - dmark != 1) begin
      errors++; $display("FAIL clr_counts got writes=%0d dones=%0d exp 4 1", clr_log.size() - mark, done_pulses - dmark); end
  endtask

  task automatic test_starve;
    bit pend, exp;
    int bad;
    lsu_write(250, 1'b1); lsu_write(299, 1'b1); lsu_write(300, 1'b1);
    pulse_start(200, 100);
    lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 5;
    pend = 0;
    for (int k = 0; k < 500; k++) begin
      #1;
      exp = (k % 5) != 4;
      checks++; if (lsu_gnt_o !== exp || clr_busy_o !== 1'b1) begin
        errors++; $display("FAIL starve_gnt k=%0d got gnt=%b busy=%b exp gnt=%b busy=1", k, lsu_gnt_o, clr_busy_o, exp); end
      if (!exp) begin
        checks++; if (tag_addr_o !== 200 + k / 5 || tag_we_o !== 1'b1) begin
          errors++; $display("FAIL starve_clr k=%0d got addr=%0d we=%b exp %0d 1", k, tag_addr_o, tag_we_o, 200 + k / 5); end
      end
      checks++; if (lsu_rvalid_o !== pend || (pend && lsu_rdata_o !== ref_get(5))) begin
        errors++; $display("FAIL starve_rd k=%0d got v=%b d=%b exp v=%b d=%b", k, lsu_rvalid_o, lsu_rdata_o, pend, ref_get(5)); end
      pend = exp;
      step;
    end
    lsu_req_i = 0;
    #1;
    checks++; if (clr_done_o !== 1'b1 || clr_busy_o !== 1'b0) begin
      errors++; $display("FAIL starve_end got done=%b busy=%b exp 1 0", clr_done_o, clr_busy_o); end
    step;
    ref_clear(200, 100);
    bad = 0;
    for (int unsigned a = 199; a <= 300; a++) if (tmem[a] !== ref_get(a)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL starve_mem got %0d wrong tags exp 0", bad); end
  endtask

  task automatic test_random_traffic;
    int bad;
    for (int trial = 0; trial < 3; trial++) begin
      int unsigned base, n, rem, run, guard;
      int mark, dmark;
      bit pend, pend_val, hold, eg;
      base = 3000 + trial * 100; n = $urandom_range(5, 20);
      rem = n; run = 0; pend = 0; pend_val = 0; hold = 0; guard = 0;
      mark = clr_log.size(); dmark = done_pulses;
      pulse_start(base, n);
      while (rem > 0 && guard < n * (L + 1) + 4) begin
        if (!hold) begin
          lsu_req_i = 1'($urandom_range(0, 1)); lsu_we_i = 1'($urandom_range(0, 1));
          lsu_addr_i = 1000 + $urandom_range(0, 31); lsu_wdata_i = 1'($urandom_range(0, 1));
        end
        #1;
        checks++; if (lsu_rvalid_o !== pend || (pend && lsu_rdata_o !== pend_val)) begin
          errors++; $display("FAIL rt_rd got v=%b d=%b exp v=%b d=%b", lsu_rvalid_o, lsu_rdata_o, pend, pend_val); end
        eg = lsu_req_i && (run < L);
        checks++; if (lsu_gnt_o !== eg || clr_busy_o !== 1'b1) begin
          errors++; $display("FAIL rt_gnt got gnt=%b busy=%b exp gnt=%b busy=1", lsu_gnt_o, clr_busy_o, eg); end
        pend = 0;
        if (eg) begin
          run++;
          if (lsu_we_i) ref_mem[lsu_addr_i] = lsu_wdata_i;
          else begin pend = 1; pend_val = ref_get(lsu_addr_i); end
        end else begin
          checks++; if (tag_we_o !== 1'b1 || tag_addr_o !== base + (n - rem)) begin
            errors++; $display("FAIL rt_clr got we=%b addr=%0d exp 1 %0d", tag_we_o, tag_addr_o, base + (n - rem)); end
          rem--; run = 0;
        end
        hold = lsu_req_i && !eg;
        step; guard++;
      end
      checks++; if (rem != 0) begin errors++; $display("FAIL rt_timeout got remaining=%0d exp 0", rem); end
      lsu_req_i = 0;
      #1;
      checks++; if (clr_done_o !== 1'b1 || lsu_rvalid_o !== pend) begin
        errors++; $display("FAIL rt_done got done=%b rv=%b exp 1 %b", clr_done_o, lsu_rvalid_o, pend); end
      step;
      ref_clear(base, n);
      bad = 0;
      if (clr_log.size() - mark != n) bad++;
      else for (int unsigned i = 0; i < n; i++) if (clr_log[mark + i] != base + i) bad++;
      checks++; if (bad != 0 || done_pulses - dmark != 1) begin
        errors++; $display("FAIL rt_log got bad=%0d dones=%0d exp 0 1", bad, done_pulses - dmark); end
    end
    bad = 0;
    for (int unsigned a = 1000; a < 1032; a++) if (tmem[a] !== ref_get(a)) bad++;
    for (int unsigned a = 2999; a < 3221; a++) if (tmem[a] !== ref_get(a)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rt_mem got %0d wrong tags exp 0", bad); end
  endtask

  task automatic run_until_done(input string name, input int unsigned base, input int unsigned count,
                                input int unsigned exp_cycles, input int unsigned exp_first, input int unsigned exp_writes);
    int mark, t, bad;
    mark = clr_log.size();
    pulse_start(base, count);
    t = 1;
    while (clr_done_o !== 1'b1 && t < 40) begin step; t++; end
    checks++; if (t != exp_cycles) begin errors++; $display("FAIL %s_latency got %0d exp %0d", name, t, exp_cycles); end
    step;
    bad = 0;
    if (clr_log.size() - mark != exp_writes) bad++;
    else for (int unsigned i = 0; i < exp_writes; i++) if (clr_log[mark + i] != exp_first + i) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL %s_writes got n=%0d exp n=%0d", name, clr_log.size() - mark, exp_writes); end
    ref_clear(base, count);
  endtask

  task automatic test_boundary;
    lsu_write(127997, 1'b1); lsu_write(127999, 1'b1); lsu_write(40, 1'b1);
    run_until_done("top", 127998, 10, 3, 127998, 2);
    checks++; if (tmem[127999] !== 1'b0 || tmem[127997] !== 1'b1) begin
      errors++; $display("FAIL top_mem got %b %b exp 0 1", tmem[127999], tmem[127997]); end
    run_until_done("zero", 40, 0, 1, 0, 0);
    checks++; if (tmem[40] !== 1'b1) begin errors++; $display("FAIL zero_mem got %b exp 1", tmem[40]); end
    run_until_done("oor", 200000, 5, 1, 0, 0);
    run_until_done("nowrap", 127990, 32'hFFFF_FFFF, 11, 127990, 10);
  endtask

  task automatic test_abort;
    int mark, dmark;
    for (int unsigned a = 0; a < 4; a++) lsu_write(a, 1'b1);
    for (int unsigned a = 30; a < 33; a++) lsu_write(a, 1'b1);
    mark = clr_log.size(); dmark = done_pulses;
    pulse_start(0, 50);
    step; step;
    clr_abort_i = 1;
    step;
    clr_abort_i = 0;
    checks++; if (clr_done_o !== 1'b1 || clr_busy_o !== 1'b0) begin
      errors++; $display("FAIL abort_done got done=%b busy=%b exp 1 0", clr_done_o, clr_busy_o); end
    step;
    clr_abort_i = 1; clr_base_i = 30; clr_count_i = 2; clr_start_i = 1;
    #1;
    checks++; if (clr_done_o !== 1'b0 || clr_busy_o !== 1'b0) begin
      errors++; $display("FAIL abort_idle got done=%b busy=%b exp 0 0", clr_done_o, clr_busy_o); end
    step;
    clr_start_i = 0; clr_abort_i = 0;
    checks++; if (clr_busy_o !== 1'b1 || tag_addr_o !== 32'd30) begin
      errors++; $display("FAIL abort_restart got busy=%b addr=%0d exp 1 30", clr_busy_o, tag_addr_o); end
    step; step;
    checks++; if (clr_done_o !== 1'b1) begin errors++; $display("FAIL abort_restart_done got %b exp 1", clr_done_o); end
    step;
    ref_clear(0, 3); ref_clear(30, 2);
    checks++; if (tmem[0] !== 0 || tmem[1] !== 0 || tmem[2] !== 0 || tmem[3] !== 1 || tmem[30] !== 0 || tmem[31] !== 0 || tmem[32] !== 1) begin
      errors++; $display("FAIL abort_mem got %b%b%b%b %b%b%b exp 0001 001", tmem[0], tmem[1], tmem[2], tmem[3], tmem[30], tmem[31], tmem[32]); end
    checks++; if (clr_log.size() - mark != 5 || done_pulses - dmark != 2) begin
      errors++; $display("FAIL abort_counts got writes=%0d dones=%0d exp 5 2", clr_log.size() - mark, done_pulses - dmark); end
  endtask

  task automatic test_reset_mid;
    int dmark;
    lsu_write(504, 1'b1); lsu_write(600, 1'b1); lsu_write(602, 1'b1);
    dmark = done_pulses;
    pulse_start(500, 20);
    step; step; step;
    lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 5;
    step;
    lsu_req_i = 0;
    checks++; if (lsu_rvalid_o !== 1'b1 || clr_busy_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got rv=%b busy=%b exp 1 1", lsu_rvalid_o, clr_busy_o); end
    #2;
    rst_i = 1;
    #1;
    checks++; if (clr_busy_o !== 0 || clr_done_o !== 0 || lsu_rvalid_o !== 0 || tag_we_o !== 0) begin
      errors++; $display("FAIL rstmid_async got busy=%b done=%b rv=%b we=%b exp 0 0 0 0", clr_busy_o, clr_done_o, lsu_rvalid_o, tag_we_o); end
    step;
    rst_i = 0;
    step;
    checks++; if (tmem[500] !== 0 || tmem[501] !== 0 || tmem[502] !== 0 || tmem[504] !== 1 || done_pulses != dmark) begin
      errors++; $display("FAIL rstmid_mem got %b%b%b %b dones=%0d exp 000 1 0", tmem[500], tmem[501], tmem[502], tmem[504], done_pulses - dmark); end
    ref_clear(500, 3);
    run_until_done("post_rst", 600, 3, 4, 600, 3);
    checks++; if (tmem[600] !== 0 || tmem[602] !== 0) begin
      errors++; $display("FAIL post_rst_mem got %b %b exp 0 0", tmem[600], tmem[602]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset;
    test_lsu_rw;
    test_clear_basic;
    test_starve;
    test_random_traffic;
    test_boundary;
    test_abort;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
